// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, data width and default baud divisor.
// The default divisor is also used by the ser_tx side.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: drops pushes when full (unless a pop frees a slot in the same cycle)
// and reports the drop as a one-cycle overrun pulse.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_cnt;
    logic [AW:0]      rd_cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             do_pop;
    logic             do_push;

    // Counters carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_cnt[AW] != rd_cnt[AW]) &&
                     (wr_cnt[AW-1:0] == rd_cnt[AW-1:0]);
    assign valid   = (wr_cnt != rd_cnt);
    assign level   = wr_cnt - rd_cnt;
    assign rdata   = mem[rd_cnt[AW-1:0]];
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_cnt[AW-1:0]] <= wdata;
                wr_cnt <= wr_cnt + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_cnt <= rd_cnt + {{AW{1'b0}}, 1'b1};
            end
            overrun <= push && full && !do_pop;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver (8 data bits, LSB first, 1 stop bit) with mid-bit sampling and receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_err port.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ser_rx,
    output logic [UART_DATA_W-1:0]        rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_W - 1);

    logic                   sync1;
    logic                   sync2;
    logic                   rx_s;
    logic [1:0]             fill;
    logic                   armed;

    rx_state_t              state;
    rx_state_t              state_n;
    logic [CW-1:0]          baud_cnt;
    logic [CW-1:0]          baud_n;
    logic [2:0]             bit_idx;
    logic [2:0]             idx_n;
    logic [UART_DATA_W-1:0] shreg;
    logic [UART_DATA_W-1:0] shreg_n;
    logic                   tick;
    logic                   push;
    logic                   ferr_n;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit;
    logic                   par_n;
    logic                   perr_n;
`endif

    assign rx_s = sync2;
    assign tick = (baud_cnt == '0);

    // fill marks when the synchronizer holds real line samples, so its
    // reset-time ones cannot arm the receiver on a line held low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= ser_rx;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            if (state == ST_IDLE && rx_s && fill[1]) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_idx   <= idx_n;
            shreg     <= shreg_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_n;
            parity_err <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        idx_n   = bit_idx;
        shreg_n = shreg;
        push    = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_bit;
        perr_n  = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (armed && !rx_s) begin
                    state_n = ST_START;
                    baud_n  = HALF_BIT;
                end
            end
            ST_START: begin
                if (!tick) begin
                    baud_n = baud_cnt - CW'(1);
                end else if (!rx_s) begin
                    state_n = ST_DATA;
                    baud_n  = FULL_BIT;
                    idx_n   = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    baud_n = baud_cnt - CW'(1);
                end else begin
                    shreg_n[bit_idx] = rx_s;
                    baud_n           = FULL_BIT;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        idx_n = bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (!tick) begin
                    baud_n = baud_cnt - CW'(1);
                end else begin
`ifdef UART_RX_PARITY_EN
                    par_n = rx_s;
`endif
                    baud_n  = FULL_BIT;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!tick) begin
                    baud_n = baud_cnt - CW'(1);
                end else if (rx_s) begin
                    state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                    if (^{shreg, par_bit}) begin
                        perr_n = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
`else
                    push = 1'b1;
`endif
                end else begin
                    // Framing error outranks parity; only this pulse is raised.
                    ferr_n  = 1'b1;
                    state_n = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    uart_rx_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push),
        .wdata   (shreg),
        .pop     (rx_ready),
        .rdata   (rx_data),
        .valid   (rx_valid),
        .overrun (overrun),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit with a 4-entry FIFO.
// Build with UART_RX_PARITY_EN defined to exercise the parity path as well.
module tb_uart_rx_core;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ser_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] fifo_level;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
    int         perr_cnt = 0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         vcyc     = 0;
    logic [7:0] popped[$];

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ser_rx     (ser_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (rx_valid === 1'b1) vcyc++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) popped.push_back(rx_data);
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) perr_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input int k, input logic [7:0] exp);
        logic [31:0] obs;
        obs = (k < popped.size()) ? {24'd0, popped[k]} : 32'hFFFF_FFFF;
        check(tag, obs, {24'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Ideal frame; with rdy_pulse, rx_ready is high only in the stop-sample cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic rdy_pulse);
        ser_rx = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 8; i++) begin
            ser_rx = d[i];
            ticks(CPB);
        end
`ifdef UART_RX_PARITY_EN
        ser_rx = (^d) ^ par_flip;
        ticks(CPB);
`endif
        ser_rx = stop_b;
        for (int c = 0; c < CPB; c++) begin
            tick();
            if (rdy_pulse && c == 9) rx_ready = 1'b1;
            if (rdy_pulse && c == 10) rx_ready = 1'b0;
        end
    endtask

    initial begin
        int base;
        int f0;
        int o0;
        int v0;

        resetn   = 1'b0;
        ser_rx   = 1'b1;
        rx_ready = 1'b0;
        ticks(3);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_ovr", 32'(overrun), 32'd0);
        resetn = 1'b1;
        ticks(6);

        // 1: clean frame
        rx_ready = 1'b1;
        base = popped.size(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = vcyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        ticks(4);
        check_pop("t1_data", base, 8'hA5);
        check("t1_vcyc", 32'(vcyc - v0), 32'd1);
        check("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("t1_ovr", 32'(ovr_cnt - o0), 32'd0);

        // 2: short glitch then a good frame
        base = popped.size(); f0 = ferr_cnt; v0 = vcyc;
        ser_rx = 1'b0;
        ticks(5);
        ser_rx = 1'b1;
        ticks(30);
        check("t2_glitch_vcyc", 32'(vcyc - v0), 32'd0);
        check("t2_glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        ticks(4);
        check_pop("t2_data", base, 8'h3C);
        check("t2_count", 32'(popped.size() - base), 32'd1);

        // 3: framing error followed by a held-low break
        base = popped.size(); f0 = ferr_cnt; v0 = vcyc;
        send_frame(8'h12, 1'b0, 1'b0);
        ser_rx = 1'b0;
        ticks(40);
        ser_rx = 1'b1;
        ticks(20);
        check("t3_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("t3_vcyc", 32'(vcyc - v0), 32'd0);
        check("t3_level", 32'(fifo_level), 32'd0);
        send_frame(8'h34, 1'b1, 1'b0);
        ticks(4);
        check_pop("t3_data", base, 8'h34);
        check("t3_ferr_after", 32'(ferr_cnt - f0), 32'd1);

        // 4: overrun on the fifth frame
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            ticks(4);
        end
        check("t4_level4", 32'(fifo_level), 32'd4);
        check("t4_ovr_before", 32'(ovr_cnt - o0), 32'd0);
        send_frame(8'h05, 1'b1, 1'b0);
        ticks(4);
        check("t4_ovr", 32'(ovr_cnt - o0), 32'd1);
        check("t4_level_full", 32'(fifo_level), 32'd4);
        check("t4_head", 32'(rx_data), 32'h01);
        base = popped.size();
        rx_ready = 1'b1;
        ticks(8);
        check_pop("t4_pop0", base, 8'h01);
        check_pop("t4_pop1", base + 1, 8'h02);
        check_pop("t4_pop2", base + 2, 8'h03);
        check_pop("t4_pop3", base + 3, 8'h04);
        check("t4_npop", 32'(popped.size() - base), 32'd4);
        check("t4_level0", 32'(fifo_level), 32'd0);

        // 5: push and pop together while full
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h11 + 8'(i), 1'b1, 1'b0);
            ticks(4);
        end
        base = popped.size();
        send_frame(8'h05, 1'b1, 1'b1);
        ticks(4);
        check("t5_level", 32'(fifo_level), 32'd4);
        check("t5_ovr", 32'(ovr_cnt - o0), 32'd0);
        check_pop("t5_popped", base, 8'h11);
        check("t5_head", 32'(rx_data), 32'h12);
        rx_ready = 1'b1;
        ticks(8);
        check_pop("t5_pop1", base + 1, 8'h12);
        check_pop("t5_pop2", base + 2, 8'h13);
        check_pop("t5_pop3", base + 3, 8'h14);
        check_pop("t5_pop4", base + 4, 8'h05);
        check("t5_level0", 32'(fifo_level), 32'd0);

        // 6: reset in the middle of bit 4, with one byte queued
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        ticks(4);
        check("t6_level_pre", 32'(fifo_level), 32'd1);
        ser_rx = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 4; i++) begin
            ser_rx = 8'hC3 >> i;
            ticks(CPB);
        end
        ser_rx = 1'b0;
        ticks(CPB / 2);
        resetn = 1'b0;
        tick();
        check("t6_rst_valid", 32'(rx_valid), 32'd0);
        check("t6_rst_data", 32'(rx_data), 32'd0);
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        check("t6_rst_ferr", 32'(frame_err), 32'd0);
        check("t6_rst_ovr", 32'(overrun), 32'd0);
        ticks(2);
        resetn = 1'b1;
        f0 = ferr_cnt; v0 = vcyc;
        ticks(CPB / 2);
        ser_rx = 1'b0;
        ticks(CPB);
        ser_rx = 1'b1;
        ticks(CPB * 3 + 20);
        check("t6_no_byte", 32'(vcyc - v0), 32'd0);
        check("t6_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        rx_ready = 1'b1;
        base = popped.size();
        send_frame(8'h96, 1'b1, 1'b0);
        ticks(4);
        check_pop("t6_data", base, 8'h96);
        check("t6_count", 32'(popped.size() - base), 32'd1);

`ifdef UART_RX_PARITY_EN
        // parity: correct even parity, then a flipped parity bit
        base = popped.size();
        f0 = perr_cnt;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        ticks(4);
        check_pop("par_good", base, 8'h07);
        check("par_good_err", 32'(perr_cnt - f0), 32'd0);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        ticks(4);
        check("par_bad_err", 32'(perr_cnt - f0), 32'd1);
        check("par_bad_count", 32'(popped.size() - base), 32'd1);
        par_flip = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
